rggen_counter_threshold_monitor: RTL and testbench

- Downstream consumer of a bit-field counter's o_count output.
- Compares the count against a software-programmable threshold and sets a sticky status on each upward crossing. Status is write-1-to-clear; the interrupt output is gated by an enable.
- Tracks the peak count since the last peak clear.
- Sits beside the counter bit field inside the generated register block; the status, threshold and peak are exposed as register fields.

---
 rtl/rggen_counter_threshold_monitor.sv | 145 ++++++++++++++
 tb/tb_rggen_counter_threshold_monitor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_counter_threshold_monitor.sv
// rggen_counter_threshold_monitor
// Watches a counter bit field's live count and compares it with a
// software-programmable threshold. Each upward crossing sets a sticky,
// write-1-to-clear status. The interrupt output is that status gated by an
// enable. The block also tracks the peak count since the last peak clear.
//
// Optional feature: define RGGEN_COUNTER_MONITOR_HYSTERESIS_EN to re-arm only
// once the count drops below (threshold - HYSTERESIS), saturated at zero.
// Without it, the FSM re-arms as soon as the count drops below the threshold.
module rggen_counter_threshold_monitor #(
    parameter int               WIDTH             = 8,
    parameter logic [WIDTH-1:0] INITIAL_THRESHOLD = {WIDTH{1'b1}},
    parameter int               HYSTERESIS        = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_sw_write_valid,
    input  logic [WIDTH-1:0] i_sw_mask,
    input  logic [WIDTH-1:0] i_sw_write_data,
    output logic [WIDTH-1:0] o_threshold,
    input  logic             i_status_clear,
    input  logic             i_irq_enable,
    output logic             o_status,
    output logic             o_irq,
    input  logic             i_peak_clear,
    output logic [WIDTH-1:0] o_peak,
    output logic             o_above
);

    typedef enum logic {
        ST_ARMED = 1'b0,
        ST_ABOVE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_threshold;
    logic [WIDTH-1:0] w_threshold_next;
    logic             r_status;
    logic             w_status_set;
    logic [WIDTH-1:0] r_peak;
    logic             w_hit;
    logic             w_hit_new;
    logic             w_rearm;

    // Masked software write: selected bits take the write data, the rest hold.
    assign w_threshold_next = (r_threshold & ~i_sw_mask) | (i_sw_write_data & i_sw_mask);

    // Live, unregistered comparison against the threshold in effect this cycle.
    assign w_hit     = (i_count >= r_threshold);
    // Comparison against the threshold that a write in this cycle installs.
    assign w_hit_new = (i_count >= w_threshold_next);

`ifdef RGGEN_COUNTER_MONITOR_HYSTERESIS_EN
    // Re-arm level: threshold minus the margin, clamped at zero.
    function automatic logic [WIDTH-1:0] sat_floor(input logic [WIDTH-1:0] thr);
        logic [WIDTH:0] diff;
        diff = {1'b0, thr} - (WIDTH+1)'(HYSTERESIS);
        return diff[WIDTH] ? '0 : diff[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] w_floor;
    assign w_floor = sat_floor(r_threshold);
    // A zero floor cannot be undercut, so an empty count is the re-arm point.
    assign w_rearm = (w_floor == '0) ? (i_count == '0) : (i_count < w_floor);
`else
    logic w_unused_hysteresis;
    assign w_unused_hysteresis = (HYSTERESIS != 0);
    assign w_rearm = (i_count < r_threshold);
`endif

    // Threshold register with per-bit write enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_threshold <= INITIAL_THRESHOLD;
        end else if (i_sw_write_valid) begin
            r_threshold <= w_threshold_next;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_ARMED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a threshold write re-evaluates the state but never
    // raises status, so reprogramming cannot cause a spurious interrupt.
    always_comb begin
        w_state_next = r_state;
        w_status_set = 1'b0;
        if (i_sw_write_valid) begin
            w_state_next = w_hit_new ? ST_ABOVE : ST_ARMED;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (w_hit) begin
                        w_state_next = ST_ABOVE;
                        w_status_set = 1'b1;
                    end
                end
                ST_ABOVE: begin
                    if (w_rearm) begin
                        w_state_next = ST_ARMED;
                    end
                end
                default: w_state_next = ST_ARMED;
            endcase
        end
    end

    // Sticky status; a crossing wins over a simultaneous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_status <= 1'b0;
        end else if (w_status_set) begin
            r_status <= 1'b1;
        end else if (i_status_clear) begin
            r_status <= 1'b0;
        end
    end

    // Peak tracker; a clear restarts from the present count, which also
    // covers a new maximum arriving in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_peak <= '0;
        end else if (i_peak_clear) begin
            r_peak <= i_count;
        end else if (i_count > r_peak) begin
            r_peak <= i_count;
        end
    end

    assign o_threshold = r_threshold;
    assign o_status    = r_status;
    assign o_irq       = r_status & i_irq_enable;
    assign o_peak      = r_peak;
    assign o_above     = (r_state == ST_ABOVE);

endmodule

// File: tb/tb_rggen_counter_threshold_monitor.sv
// Scoreboard bench for rggen_counter_threshold_monitor (default build).
// The stimulus process queues hand-computed expectations tagged with the
// clock edge after which they hold; a monitor process checks them 1 ns after
// each rising edge. A second instance with INITIAL_THRESHOLD = 0 covers the
// zero-threshold case.
module tb_rggen_counter_threshold_monitor;

    typedef struct {
        string      name;
        int         cyc;
        int         field;
        logic [7:0] value;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] count;
    logic       wv;
    logic [7:0] mask;
    logic [7:0] wdata;
    logic       sclr;
    logic       pclr;
    logic       irq_en;

    logic [7:0] thr, peak, thr0, peak0;
    logic       status, irq, above, status0, irq0, above0;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    rggen_counter_threshold_monitor #(
        .WIDTH(8), .INITIAL_THRESHOLD(8'hFF), .HYSTERESIS(0)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_count(count),
        .i_sw_write_valid(wv), .i_sw_mask(mask), .i_sw_write_data(wdata),
        .o_threshold(thr), .i_status_clear(sclr), .i_irq_enable(irq_en),
        .o_status(status), .o_irq(irq), .i_peak_clear(pclr),
        .o_peak(peak), .o_above(above)
    );

    rggen_counter_threshold_monitor #(
        .WIDTH(8), .INITIAL_THRESHOLD(8'h00), .HYSTERESIS(0)
    ) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_count(count),
        .i_sw_write_valid(1'b0), .i_sw_mask(8'h00), .i_sw_write_data(8'h00),
        .o_threshold(thr0), .i_status_clear(1'b0), .i_irq_enable(1'b1),
        .o_status(status0), .o_irq(irq0), .i_peak_clear(1'b0),
        .o_peak(peak0), .o_above(above0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] read_field(input int f);
        case (f)
            0: return thr;
            1: return {7'd0, status};
            2: return {7'd0, irq};
            3: return peak;
            4: return {7'd0, above};
            5: return thr0;
            6: return {7'd0, status0};
            7: return {7'd0, irq0};
            8: return peak0;
            default: return {7'd0, above0};
        endcase
    endfunction

    // Monitor: after every rising edge, check all expectations due now.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                e = q.pop_front();
                chk(e.name, read_field(e.field), e.value);
            end
        end
    end

    // Expectation for the outputs just after the coming rising edge.
    task automatic expect_f(input string name, input int f, input logic [7:0] v);
        exp_t e;
        e.name = name; e.cyc = cyc + 1; e.field = f; e.value = v;
        q.push_back(e);
    endtask

    task automatic drive(input logic [7:0] c, input logic w, input logic [7:0] m,
                         input logic [7:0] d, input logic sc, input logic pc,
                         input logic ie);
        count = c; wv = w; mask = m; wdata = d; sclr = sc; pclr = pc; irq_en = ie;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(8'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_thr", thr, 8'hFF);
        chk("rst_status", {7'd0, status}, 8'd0);
        chk("rst_irq", {7'd0, irq}, 8'd0);
        chk("rst_peak", peak, 8'd0);
        chk("rst_above", {7'd0, above}, 8'd0);
        chk("rst_thr0", thr0, 8'h00);
        rst_n = 1'b1;

        // Program threshold 10 while counting 8.
        drive(8'd8, 1'b1, 8'hFF, 8'd10, 1'b0, 1'b0, 1'b0);
        expect_f("wr10_thr", 0, 8'd10);
        expect_f("wr10_above", 4, 8'd0);
        expect_f("wr10_status", 1, 8'd0);
        expect_f("ramp8_peak", 3, 8'd8);
        expect_f("zero_thr_status0", 6, 8'd1);
        expect_f("zero_thr_above0", 9, 8'd1);
        expect_f("zero_thr_irq0", 7, 8'd1);
        expect_f("zero_thr_peak0", 8, 8'd8);
        tick();
        drive(8'd9, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        expect_f("ramp9_status", 1, 8'd0);
        expect_f("ramp9_above", 4, 8'd0);
        tick();
        drive(8'd10, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        expect_f("cross10_status", 1, 8'd1);
        expect_f("cross10_above", 4, 8'd1);
        expect_f("cross10_irq_dis", 2, 8'd0);
        tick();
        drive(8'd11, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        expect_f("ramp11_irq_en", 2, 8'd1);
        expect_f("ramp11_peak", 3, 8'd11);
        tick();
        // Drop below threshold re-arms; re-cross together with a clear.
        drive(8'd9, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        expect_f("rearm9_above", 4, 8'd0);
        expect_f("rearm9_status", 1, 8'd1);
        tick();
        drive(8'd10, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        expect_f("recross_clr_status", 1, 8'd1);
        expect_f("recross_above", 4, 8'd1);
        tick();
        drive(8'd12, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        expect_f("clr_above_status", 1, 8'd0);
        expect_f("clr_above_irq", 2, 8'd0);
        expect_f("clr_above_above", 4, 8'd1);
        tick();
        drive(8'd12, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        expect_f("no_retrigger_status", 1, 8'd0);
        tick();
        // Reprogramming at count 20: 30 then 15.
        drive(8'd20, 1'b1, 8'hFF, 8'd30, 1'b0, 1'b0, 1'b1);
        expect_f("wr30_above", 4, 8'd0);
        expect_f("wr30_thr", 0, 8'd30);
        tick();
        drive(8'd20, 1'b1, 8'hFF, 8'd15, 1'b0, 1'b0, 1'b1);
        expect_f("wr15_above", 4, 8'd1);
        expect_f("wr15_status", 1, 8'd0);
        expect_f("wr15_irq", 2, 8'd0);
        tick();
        drive(8'd20, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        expect_f("after_wr15_status", 1, 8'd0);
        expect_f("after_wr15_above", 4, 8'd1);
        tick();
        // Partial mask write.
        drive(8'd0, 1'b1, 8'hFF, 8'h30, 1'b0, 1'b0, 1'b1);
        expect_f("wr30h_thr", 0, 8'h30);
        expect_f("wr30h_above", 4, 8'd0);
        tick();
        drive(8'd0, 1'b1, 8'h0F, 8'h05, 1'b0, 1'b0, 1'b1);
        expect_f("mask_thr", 0, 8'h35);
        expect_f("mask_peak_hold", 3, 8'd20);
        tick();
        // Peak tracking.
        drive(8'd3, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        expect_f("pclr3_peak", 3, 8'd3);
        tick();
        drive(8'd7, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        expect_f("peak7", 3, 8'd7);
        tick();
        drive(8'd5, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        expect_f("peak7_hold", 3, 8'd7);
        tick();
        drive(8'd5, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        expect_f("pclr5_peak", 3, 8'd5);
        tick();
        // All-ones threshold and count wrap.
        drive(8'd254, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
        expect_f("wrFF_above", 4, 8'd0);
        expect_f("wrFF_peak", 3, 8'd254);
        tick();
        drive(8'd254, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        expect_f("cnt254_status", 1, 8'd0);
        tick();
        drive(8'd255, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        expect_f("max_status", 1, 8'd1);
        expect_f("max_above", 4, 8'd1);
        expect_f("max_peak", 3, 8'd255);
        tick();
        drive(8'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        expect_f("wrap_above", 4, 8'd0);
        expect_f("wrap_peak", 3, 8'd255);
        expect_f("wrap_status", 1, 8'd1);
        expect_f("zero_thr_hold_above0", 9, 8'd1);
        expect_f("zero_thr_hold_status0", 6, 8'd1);
        tick();
        drive(8'd0, 1'b1, 8'hFF, 8'h40, 1'b0, 1'b0, 1'b1);
        expect_f("wr40_thr", 0, 8'h40);
        expect_f("wr40_status_hold", 1, 8'd1);
        tick();

        // Asynchronous reset mid-cycle, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_thr", thr, 8'hFF);
        chk("arst_status", {7'd0, status}, 8'd0);
        chk("arst_irq", {7'd0, irq}, 8'd0);
        chk("arst_peak", peak, 8'd0);
        chk("arst_above", {7'd0, above}, 8'd0);
        chk("arst_status0", {7'd0, status0}, 8'd0);
        chk("arst_above0", {7'd0, above0}, 8'd0);
        chk("arst_peak0", peak0, 8'd0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 8'(q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
